// File: rtl/nand_truth_table_checker.sv
// Sweeps every input vector of an N-input NAND gate in ascending order.
// Each vector is held for HOLD_CYCLES cycles before the fed-back gate output
// is sampled. The block reports the error count, the first failing vector and
// a pass flag.
module nand_truth_table_checker #(
    parameter int N_INPUTS    = 2,
    parameter int HOLD_CYCLES = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [N_INPUTS-1:0] a_out,
    input  logic                c_in,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_INPUTS:0]   err_count,
    output logic                mismatch,
    output logic                fail_valid,
    output logic [N_INPUTS-1:0] first_fail_vec
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int EW = N_INPUTS + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [HW-1:0]       hold_cnt;
    logic [N_INPUTS-1:0] vec;
    logic                sample_edge;
    logic                last_vec;
    logic                expected;
    logic                start_run;

    // Sample-point, end-of-sweep and launch decode.
    always_comb begin
        sample_edge = (state == S_DRIVE) && (hold_cnt == HW'(HOLD_CYCLES - 1));
        last_vec    = &vec;
        expected    = ~&vec;
        start_run   = start && ((state == S_IDLE) || (state == S_DONE));
    end

    // Next-state logic: start launches a sweep; the last sample ends it.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_DRIVE;
            S_DRIVE: if (sample_edge && last_vec) state_nxt = S_DONE;
            S_DONE:  if (start) state_nxt = S_DRIVE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Vector stepping, hold counting and result accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec            <= '0;
            hold_cnt       <= '0;
            err_count      <= '0;
            mismatch       <= 1'b0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
        end else begin
            mismatch <= 1'b0;
            if (start_run) begin
                vec            <= '0;
                hold_cnt       <= '0;
                err_count      <= '0;
                fail_valid     <= 1'b0;
                first_fail_vec <= '0;
            end else if (state == S_DRIVE) begin
                if (sample_edge) begin
                    hold_cnt <= '0;
                    if (!last_vec) vec <= vec + N_INPUTS'(1);
                    if (c_in != expected) begin
                        err_count <= err_count + EW'(1);
                        mismatch  <= 1'b1;
                        if (!fail_valid) begin
                            fail_valid     <= 1'b1;
                            first_fail_vec <= vec;
                        end
                    end
                end else begin
                    hold_cnt <= hold_cnt + HW'(1);
                end
            end
        end
    end

    // Status outputs decode straight from registered state, so c_in has no
    // combinational path to them; a_out drops to 0 outside DRIVE.
    assign busy  = (state == S_DRIVE);
    assign done  = (state == S_DONE);
    assign pass  = (state == S_DONE) && (err_count == '0);
    assign a_out = (state == S_DRIVE) ? vec : '0;

endmodule

// File: tb/tb_nand_truth_table_checker.sv
// Scoreboard bench: each sweep pushes its expected per-cycle outputs, and a
// monitor pops and compares them one cycle at a time.
module tb_nand_truth_table_checker;

    typedef struct {
        int a;
        int busy;
        int done;
        int mm;
        int pass;
        int errc;
        int fv;
        int ffv;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1;
    logic [1:0] a0;
    logic [2:0] a1;
    logic       c0, c1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic [2:0] errc0;
    logic [3:0] errc1;
    logic       mm0, mm1, fv0, fv1;
    logic [1:0] ffv0;
    logic [2:0] ffv1;

    int   mode;
    int   sel;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    nand_truth_table_checker #(.N_INPUTS(2), .HOLD_CYCLES(5)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .a_out(a0), .c_in(c0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(errc0),
        .mismatch(mm0), .fail_valid(fv0), .first_fail_vec(ffv0)
    );

    nand_truth_table_checker #(.N_INPUTS(3), .HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_out(a1), .c_in(c1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(errc1),
        .mismatch(mm1), .fail_valid(fv1), .first_fail_vec(ffv1)
    );

    // Gate under test: 0 = NAND, 1 = stuck at 0, 2 = AND, 3 = stuck at 1.
    function automatic logic gate_model(input int v, input int n, input int m);
        logic nand_v;
        nand_v = (v != (1 << n) - 1);
        case (m)
            0:       return nand_v;
            1:       return 1'b0;
            2:       return ~nand_v;
            default: return 1'b1;
        endcase
    endfunction

    always_comb c0 = gate_model(int'(a0), 2, mode);
    always_comb c1 = gate_model(int'(a1), 3, mode);

    task automatic check(input string tag, input logic [31:0] got, input int expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel == 0) start0 = v;
        else          start1 = v;
    endtask

    // Launch a sweep; rst_at / restart_at (0 = none) assert rst / start so
    // they are sampled at edge t0+j.
    task automatic do_sweep(input int nin, input int hold, input int m,
                            input int rst_at, input int restart_at);
        int   n_vec;
        int   span;
        int   last;
        exp_t e;
        n_vec = 1 << nin;
        span  = n_vec * hold;
        last  = span + 2;
        mode  = m;
        @(posedge clk); #1;
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        for (int j = 0; j <= last; j++) begin
            e = '{default: 0};
            if (!(rst_at > 0 && j >= rst_at)) begin
                e.a    = (j < span) ? j / hold : 0;
                e.busy = (j < span) ? 1 : 0;
                e.done = (j < span) ? 0 : 1;
                if (j > 0 && j <= span && (j % hold) == 0)
                    e.mm = (gate_model(j / hold - 1, nin, m) !=
                            gate_model(j / hold - 1, nin, 0)) ? 1 : 0;
                for (int v = 0; v < n_vec; v++) begin
                    if ((v + 1) * hold <= j &&
                        gate_model(v, nin, m) != gate_model(v, nin, 0)) begin
                        if (e.fv == 0) e.ffv = v;
                        e.fv = 1;
                        e.errc++;
                    end
                end
                e.pass = (e.done == 1 && e.errc == 0) ? 1 : 0;
            end
            exp_q.push_back(e);
        end
        for (int j = 1; j <= last; j++) begin
            if (j == rst_at)     rst = 1'b1;
            if (j == restart_at) set_start(1'b1);
            @(posedge clk); #1;
            rst = 1'b0;
            set_start(1'b0);
        end
        #5;
        check("sb_drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: compare one scoreboard entry per cycle, 2 ns after the edge.
    initial begin
        forever begin
            @(posedge clk); #2;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("a_out",          (sel == 0) ? 32'(a0)    : 32'(a1),    mon_e.a);
                check("busy",           (sel == 0) ? 32'(busy0) : 32'(busy1), mon_e.busy);
                check("done",           (sel == 0) ? 32'(done0) : 32'(done1), mon_e.done);
                check("mismatch",       (sel == 0) ? 32'(mm0)   : 32'(mm1),   mon_e.mm);
                check("pass",           (sel == 0) ? 32'(pass0) : 32'(pass1), mon_e.pass);
                check("err_count",      (sel == 0) ? 32'(errc0) : 32'(errc1), mon_e.errc);
                check("fail_valid",     (sel == 0) ? 32'(fv0)   : 32'(fv1),   mon_e.fv);
                check("first_fail_vec", (sel == 0) ? 32'(ffv0)  : 32'(ffv1),  mon_e.ffv);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        mode   = 0;
        sel    = 0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_a_out",   32'(a0),    0);
        check("rst_busy",    32'(busy0), 0);
        check("rst_done",    32'(done0), 0);
        check("rst_errc",    32'(errc0), 0);
        check("rst_ffv",     32'(ffv0),  0);
        // rst and start together: rst wins.
        start0 = 1'b1;
        @(posedge clk); #2;
        check("rst_vs_start", 32'(busy0), 0);
        #1;
        rst    = 1'b0;
        start0 = 1'b0;

        do_sweep(2, 5, 0, 0, 0);    // clean NAND
        do_sweep(2, 5, 1, 0, 0);    // stuck at 0, restarted from DONE
        do_sweep(2, 5, 2, 0, 0);    // AND instead of NAND
        do_sweep(2, 5, 0, 12, 0);   // reset mid-sweep
        do_sweep(2, 5, 0, 0, 0);    // clean sweep from IDLE after abort
        do_sweep(2, 5, 1, 0, 0);    // failing sweep ...
        do_sweep(2, 5, 0, 0, 8);    // ... then restart clears; start at t0+8 ignored

        sel = 1;
        do_sweep(3, 1, 3, 0, 0);    // N=3, HOLD=1, stuck at 1

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
